// File: rtl/demo_pkg.sv
// ============================================================================
//  Module      : demo_pkg
//  Description : Shared sizes, sort-FSM state type and RAM init table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demo_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        READ_A = 3'd0,
        READ_B = 3'd1,
        CMP    = 3'd2,
        WR_A   = 3'd3,
        WR_B   = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } sort_state_t;

    // Power-up contents: a scrambled permutation of 0..15 duplicated into both bytes
    function automatic logic [DATA_W-1:0] init_word(input int i);
        logic [7:0] p;
        p = 8'((7 * i + 3) % 16);
        return {p, p};
    endfunction

endpackage

`default_nettype wire

// File: rtl/demo_btn_edge.sv
// ============================================================================
//  Module      : demo_btn_edge
//  Description : Button synchronizer and rising-edge pulse; DEMO_BTN_DEBOUNCE_EN
//                inserts a stable-level debounce before the edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demo_btn_edge
`ifdef DEMO_BTN_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic edge_out
);

    logic r_s1;
    logic r_s2;
    logic r_lvl_q;
    logic w_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

`ifdef DEMO_BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    // Level only flips after the new value has been seen on every one of the last cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (r_s2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_db  <= r_s2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_lvl = r_db;
`else
    assign w_lvl = r_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_q <= 1'b0;
        end else begin
            r_lvl_q <= w_lvl;
        end
    end

    assign edge_out = w_lvl & ~r_lvl_q;

endmodule

`default_nettype wire

// File: rtl/demo_wrapper.sv
// ============================================================================
//  Module      : demo_wrapper
//  Description : Board demo - bubble-sorts a 16-word RAM after reset, then lets
//                a button step through it. DEMO_BTN_DEBOUNCE_EN enables debounce.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demo_wrapper
    import demo_pkg::*;
#(
    parameter int DATA_W = demo_pkg::DATA_W,
    parameter int DEPTH  = demo_pkg::DEPTH
`ifdef DEMO_BTN_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 4
`endif
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RAMSel,
    input  logic              button,
    output logic [DATA_W-1:0] out
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]     c_last   = AW'(DEPTH - 2);
    localparam logic [AW-1:0]     c_top    = AW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    sort_state_t       r_state;
    logic [AW-1:0]     r_pass;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     r_ptr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [7:0]        r_swap_cnt;
    logic [DATA_W-1:0] r_out;

    logic              w_done;
    logic              w_btn_edge;
    logic [AW-1:0]     w_idx_p1;
    logic              w_last_idx;
    logic [DATA_W-1:0] w_status;

    assign w_done     = (r_state == DONE);
    assign w_idx_p1   = r_idx + 1'b1;
    assign w_last_idx = (r_idx == (c_last - r_pass));
    assign w_status   = DATA_W'({w_done, 7'b0, r_swap_cnt});

`ifdef DEMO_BTN_DEBOUNCE_EN
    demo_btn_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (button),
        .edge_out (w_btn_edge)
    );
`else
    demo_btn_edge u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (button),
        .edge_out (w_btn_edge)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(init_word(i));
            end
            r_state    <= READ_A;
            r_pass     <= '0;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_swap_cnt <= '0;
        end else begin
            case (r_state)
                READ_A: begin
                    r_a     <= r_mem[r_idx];
                    r_state <= READ_B;
                end
                READ_B: begin
                    r_b     <= r_mem[w_idx_p1];
                    r_state <= CMP;
                end
                CMP: begin
                    r_state <= (r_a > r_b) ? WR_A : NEXT;
                end
                WR_A: begin
                    r_mem[r_idx] <= r_b;
                    r_state      <= WR_B;
                end
                WR_B: begin
                    r_mem[w_idx_p1] <= r_a;
                    if (r_swap_cnt != 8'hFF) begin
                        r_swap_cnt <= r_swap_cnt + 1'b1;
                    end
                    r_state <= NEXT;
                end
                NEXT: begin
                    if (w_last_idx) begin
                        r_idx <= '0;
                        if (r_pass == c_last) begin
                            r_state <= DONE;
                        end else begin
                            r_pass  <= r_pass + 1'b1;
                            r_state <= READ_A;
                        end
                    end else begin
                        r_idx   <= w_idx_p1;
                        r_state <= READ_A;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= READ_A;
                end
            endcase
        end
    end

    // Presses are only meaningful once the RAM is sorted and on display
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_btn_edge && RAMSel && w_done) begin
            r_ptr <= (r_ptr == c_top) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= RAMSel ? r_mem[r_ptr] : w_status;
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_demo_wrapper.sv
// ============================================================================
//  Module      : tb_demo_wrapper
//  Description : Scoreboard bench for demo_wrapper against a sorted-table model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demo_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        RAMSel;
    logic        button;
    logic [15:0] out;

    demo_wrapper dut (
        .clk    (clk),
        .rst    (rst),
        .RAMSel (RAMSel),
        .button (button),
        .out    (out)
    );

    always #5 clk = ~clk;

`ifdef DEMO_BTN_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          c0       = 0;
    logic [15:0] init_tab   [16];
    logic [15:0] sorted_tab [16];
    logic [15:0] done_word;
    int          swaps;
    int          mptr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if ((out & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
                n_fails++;
                $display("FAIL %s: out=0x%04h expected 0x%04h (mask 0x%04h) t=%0t",
                         mon_e.name, out, mon_e.exp, mon_e.mask, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_m(input logic [15:0] v, input logic [15:0] m, input string nm);
        exp_t e;
        e.exp  = v;
        e.mask = m;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic expect_out(input logic [15:0] v, input string nm);
        expect_m(v, 16'hFFFF, nm);
    endtask

    task automatic pulse(input int hi, input int lo);
        button = 1'b1;
        tick(hi);
        button = 1'b0;
        tick(lo);
    endtask

    task automatic rand_pulse();
        pulse($urandom_range(5, 9), $urandom_range(8, 12));
    endtask

    task automatic do_reset(input logic sel, input string nm);
        rst = 1'b1;
        tick(1);
        c0     = cyc;
        rst    = 1'b0;
        RAMSel = sel;
        mptr   = 0;
        expect_out(16'h0000, nm);
    endtask

    task automatic wait_sorted();
        while (cyc - c0 < 602) tick(1);
    endtask

    initial begin
        // Reference: INIT table, its ascending order, and inversion count = bubble swaps
        for (int i = 0; i < 16; i++) begin
            logic [7:0] pb;
            pb = 8'((7 * i + 3) % 16);
            init_tab[i] = {pb, pb};
        end
        swaps = 0;
        for (int i = 0; i < 16; i++) begin
            int rank;
            rank = 0;
            for (int k = 0; k < 16; k++) begin
                if (init_tab[k] < init_tab[i]) rank++;
                if (k > i && init_tab[k] < init_tab[i]) swaps++;
            end
            sorted_tab[rank] = init_tab[i];
        end
        done_word = {1'b1, 7'b0, 8'(swaps)};

        rst    = 1'b1;
        RAMSel = 1'b0;
        button = 1'b0;
        mptr   = 0;
        tick(2);

        do_reset(1'b0, "reset_out");
        tick(1);
        expect_out(16'h0000, "status_after_reset");
        tick(98);
        expect_m(16'h0000, 16'h8000, "not_done_early");

        // Presses during the sort must be dropped whatever RAMSel says
        for (int k = 0; k < 4; k++) begin
            RAMSel = 1'($urandom_range(0, 1));
            rand_pulse();
        end
        RAMSel = 1'b0;
        wait_sorted();
        expect_out(done_word, "sort_done_status");

        RAMSel = 1'b1;
        tick(1);
        expect_out(sorted_tab[0], "ptr_held_during_sort");

        RAMSel = 1'b0;
        for (int k = 0; k < 3; k++) rand_pulse();
        expect_out(done_word, "status_ramsel0");
        RAMSel = 1'b1;
        tick(1);
        expect_out(sorted_tab[0], "ramsel0_press_discard");

        // Exact press-to-display latency
        button = 1'b1;
        tick(3 + DB);
        expect_out(sorted_tab[mptr], "latency_before");
        tick(1);
        mptr = (mptr + 1) % 16;
        expect_out(sorted_tab[mptr], "latency_after");
        button = 1'b0;
        tick(12);

        button = 1'b1;
        tick(100);
        button = 1'b0;
        tick(12);
        mptr = (mptr + 1) % 16;
        expect_out(sorted_tab[mptr], "hold_one_step");

`ifdef DEMO_BTN_DEBOUNCE_EN
        button = 1'b1;
        tick(2);
        button = 1'b0;
        tick(12);
        expect_out(sorted_tab[mptr], "glitch_ignored");
`endif

        // Random walk through the sorted RAM, covering the wrap, with RAMSel=0 presses mixed in
        for (int k = 0; k < 22; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                RAMSel = 1'b0;
                rand_pulse();
                expect_out(done_word, "step_status");
                RAMSel = 1'b1;
                tick(1);
            end
            rand_pulse();
            mptr = (mptr + 1) % 16;
            expect_out(sorted_tab[mptr], "step");
        end

        // Reset in the middle of a sort restarts from INIT
        RAMSel = 1'b0;
        do_reset(1'b0, "reset2_out");
        tick(49);
        do_reset(1'b1, "midsort_reset_out");
        tick(1);
        expect_out(init_tab[0], "restart_live_ram");
        rand_pulse();
        rand_pulse();
        RAMSel = 1'b0;
        wait_sorted();
        expect_out(done_word, "resort_done_status");
        RAMSel = 1'b1;
        tick(1);
        expect_out(sorted_tab[0], "resort_ptr0");

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) tick(1);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
